// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// main pipeline writeback (P) and the multi-cycle unit (M). P has fixed
// priority; a saturating wait counter forces a grant to M once it has lost
// STARVE_LIMIT consecutive cycles. The winning write is registered so the
// regfile sees exactly one clean write per cycle.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int RFIDX_WIDTH  = 5,
  parameter int ADDR_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic [RFIDX_WIDTH-1:0] p_wa,
  input  logic [XLEN-1:0]        p_wd,
  input  logic [ADDR_SIZE-1:0]   p_pc,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [RFIDX_WIDTH-1:0] m_wa,
  input  logic [XLEN-1:0]        m_wd,
  input  logic [ADDR_SIZE-1:0]   m_pc,
  output logic                   rf_we,
  output logic [RFIDX_WIDTH-1:0] rf_wa,
  output logic [XLEN-1:0]        rf_wd,
  output logic [ADDR_SIZE-1:0]   rf_pc,
  output logic                   m_forced
);

  // Counter threshold in the counter's own 4-bit width.
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic                   grant_p_s;
  logic                   grant_m_s;
  logic                   xfer_s;
  logic [RFIDX_WIDTH-1:0] sel_wa_s;
  logic [XLEN-1:0]        sel_wd_s;
  logic [ADDR_SIZE-1:0]   sel_pc_s;

  logic [3:0]             wait_d,   wait_q;
  logic                   rf_we_d,  rf_we_q;
  logic [RFIDX_WIDTH-1:0] rf_wa_d,  rf_wa_q;
  logic [XLEN-1:0]        rf_wd_d,  rf_wd_q;
  logic [ADDR_SIZE-1:0]   rf_pc_d,  rf_pc_q;
  logic                   forced_d, forced_q;

  // Grant decision: P by default, M when alone or when starved; nothing in reset.
  always_comb begin
    grant_p_s = 1'b0;
    grant_m_s = 1'b0;
    if (!rstn) begin
      grant_p_s = 1'b0;
      grant_m_s = 1'b0;
    end else if (m_valid && (!p_valid || (wait_q >= LIMIT_C))) begin
      grant_m_s = 1'b1;
    end else if (p_valid) begin
      grant_p_s = 1'b1;
    end else begin
      grant_p_s = 1'b0;
      grant_m_s = 1'b0;
    end
  end

  assign p_ready = grant_p_s;
  assign m_ready = grant_m_s;
  assign xfer_s  = grant_p_s | grant_m_s;

  // Payload select from the winning source.
  always_comb begin
    sel_wa_s = p_wa;
    sel_wd_s = p_wd;
    sel_pc_s = p_pc;
    if (grant_m_s) begin
      sel_wa_s = m_wa;
      sel_wd_s = m_wd;
      sel_pc_s = m_pc;
    end else begin
      sel_wa_s = p_wa;
      sel_wd_s = p_wd;
      sel_pc_s = p_pc;
    end
  end

  // Starvation counter: counts cycles M waited behind P, saturating at the limit.
  always_comb begin
    wait_d = wait_q;
    if (!m_valid || grant_m_s) begin
      wait_d = 4'd0;
    end else if (grant_p_s && (wait_q < LIMIT_C)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Output register next state: load on transfer, x0 writes consumed without we.
  always_comb begin
    rf_we_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    rf_pc_d  = rf_pc_q;
    forced_d = 1'b0;
    if (xfer_s) begin
      rf_we_d  = (sel_wa_s != {RFIDX_WIDTH{1'b0}});
      rf_wa_d  = sel_wa_s;
      rf_wd_d  = sel_wd_s;
      rf_pc_d  = sel_pc_s;
      forced_d = grant_m_s & p_valid;
    end else begin
      rf_we_d  = 1'b0;
      forced_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q   <= 4'd0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= {RFIDX_WIDTH{1'b0}};
      rf_wd_q  <= {XLEN{1'b0}};
      rf_pc_q  <= {ADDR_SIZE{1'b0}};
      forced_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      rf_pc_q  <= rf_pc_d;
      forced_q <= forced_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign rf_pc    = rf_pc_q;
  assign m_forced = forced_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: one instance with STARVE_LIMIT=4 and
// one with STARVE_LIMIT=0, sharing the same stimulus.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        p_valid;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        m_valid;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_pc;

  logic        p_ready, m_ready, rf_we, m_forced;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_pc;

  logic        p_ready0, m_ready0, rf_we0, m_forced0;
  logic [4:0]  rf_wa0;
  logic [31:0] rf_wd0, rf_pc0;

  int total;
  int bad;

  wb_port_arbiter #(.XLEN(32), .RFIDX_WIDTH(5), .ADDR_SIZE(32), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rstn(rstn),
    .p_valid(p_valid), .p_ready(p_ready), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_pc(rf_pc), .m_forced(m_forced)
  );

  wb_port_arbiter #(.XLEN(32), .RFIDX_WIDTH(5), .ADDR_SIZE(32), .STARVE_LIMIT(0)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .p_valid(p_valid), .p_ready(p_ready0), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready0), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc),
    .rf_we(rf_we0), .rf_wa(rf_wa0), .rf_wd(rf_wd0), .rf_pc(rf_pc0), .m_forced(m_forced0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rstn    = 1'b0;
    p_valid = 1'b1;
    p_wa    = 5'd5;
    p_wd    = 32'hDEAD_BEEF;
    p_pc    = 32'h0000_0100;
    m_valid = 1'b0;
    m_wa    = 5'd0;
    m_wd    = 32'h0;
    m_pc    = 32'h0;

    // Reset held with a pending P request: nothing accepted, nothing written.
    #1;
    check("rst_p_ready", {63'd0, p_ready}, 64'd0);
    check("rst_rf_we",   {63'd0, rf_we},   64'd0);
    step();
    step();
    check("rst_p_ready2", {63'd0, p_ready}, 64'd0);
    check("rst_rf_we2",   {63'd0, rf_we},   64'd0);
    check("rst_rf_wa",    {59'd0, rf_wa},   64'd0);
    check("rst_rf_wd",    {32'd0, rf_wd},   64'd0);
    rstn = 1'b1;
    #1;
    check("rel_p_ready", {63'd0, p_ready}, 64'd1);
    step();
    check("rel_rf_we", {63'd0, rf_we}, 64'd1);
    check("rel_rf_wa", {59'd0, rf_wa}, 64'd5);
    check("rel_rf_wd", {32'd0, rf_wd}, 64'hDEAD_BEEF);
    check("rel_rf_pc", {32'd0, rf_pc}, 64'h100);

    // P back-to-back x1..x4, M idle.
    for (int i = 1; i <= 4; i++) begin
      p_valid = 1'b1;
      p_wa    = 5'(i);
      p_wd    = 32'(i);
      p_pc    = 32'h0000_1000 + 32'(i * 4);
      #1;
      check("b2b_p_ready", {63'd0, p_ready}, 64'd1);
      step();
      check("b2b_rf_we", {63'd0, rf_we}, 64'd1);
      check("b2b_rf_wa", {59'd0, rf_wa}, 64'(i));
      check("b2b_rf_wd", {32'd0, rf_wd}, 64'(i));
      check("b2b_rf_pc", {32'd0, rf_pc}, 64'h1000 + 64'(i * 4));
    end
    p_valid = 1'b0;
    step();
    check("b2b_idle_we", {63'd0, rf_we}, 64'd0);
    check("b2b_idle_wa", {59'd0, rf_wa}, 64'd4);

    // Contention: P wins four cycles, then M is force-granted.
    m_valid = 1'b1;
    m_wa    = 5'd7;
    m_wd    = 32'h77;
    m_pc    = 32'h0000_2000;
    for (int c = 0; c < 4; c++) begin
      p_valid = 1'b1;
      p_wa    = 5'(10 + c);
      p_wd    = 32'h100 + 32'(c);
      #1;
      check("starve_p_ready", {63'd0, p_ready}, 64'd1);
      check("starve_m_ready", {63'd0, m_ready}, 64'd0);
      step();
      check("starve_rf_wa", {59'd0, rf_wa},    64'(10 + c));
      check("starve_forced", {63'd0, m_forced}, 64'd0);
    end
    p_wa = 5'd20;
    p_wd = 32'h200;
    #1;
    check("force_m_ready", {63'd0, m_ready}, 64'd1);
    check("force_p_ready", {63'd0, p_ready}, 64'd0);
    step();
    check("force_rf_we",  {63'd0, rf_we},    64'd1);
    check("force_rf_wa",  {59'd0, rf_wa},    64'd7);
    check("force_rf_wd",  {32'd0, rf_wd},    64'h77);
    check("force_rf_pc",  {32'd0, rf_pc},    64'h2000);
    check("force_forced", {63'd0, m_forced}, 64'd1);
    // Counter cleared by the M grant: P wins again straight away.
    m_wa = 5'd8;
    m_wd = 32'h88;
    #1;
    check("after_p_ready", {63'd0, p_ready}, 64'd1);
    check("after_m_ready", {63'd0, m_ready}, 64'd0);
    step();
    check("after_rf_wa",  {59'd0, rf_wa},    64'd20);
    check("after_forced", {63'd0, m_forced}, 64'd0);
    m_valid = 1'b0;

    // Write to x0 is consumed without a write enable; next write to x3 lands.
    p_valid = 1'b1;
    p_wa    = 5'd0;
    p_wd    = 32'hFFFF_FFFF;
    #1;
    check("x0_p_ready", {63'd0, p_ready}, 64'd1);
    step();
    check("x0_rf_we", {63'd0, rf_we}, 64'd0);
    check("x0_rf_wd", {32'd0, rf_wd}, 64'hFFFF_FFFF);
    p_wa = 5'd3;
    p_wd = 32'h33;
    step();
    check("x3_rf_we", {63'd0, rf_we}, 64'd1);
    check("x3_rf_wa", {59'd0, rf_wa}, 64'd3);
    check("x3_rf_wd", {32'd0, rf_wd}, 64'h33);

    // STARVE_LIMIT=0 instance: M always wins while valid.
    p_valid = 1'b1;
    p_wa    = 5'd2;
    p_wd    = 32'h22;
    m_valid = 1'b1;
    m_wa    = 5'd9;
    m_wd    = 32'h99;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lim0_m_ready", {63'd0, m_ready0}, 64'd1);
      check("lim0_p_ready", {63'd0, p_ready0}, 64'd0);
      step();
      check("lim0_rf_wa",   {59'd0, rf_wa0},    64'd9);
      check("lim0_forced",  {63'd0, m_forced0}, 64'd1);
    end

    // Async reset mid-contention on the limit-4 instance (counter is nonzero here).
    #2;
    rstn = 1'b0;
    #1;
    check("arst_rf_we",   {63'd0, rf_we},    64'd0);
    check("arst_rf_wa",   {59'd0, rf_wa},    64'd0);
    check("arst_rf_wd",   {32'd0, rf_wd},    64'd0);
    check("arst_rf_pc",   {32'd0, rf_pc},    64'd0);
    check("arst_forced",  {63'd0, m_forced}, 64'd0);
    check("arst_p_ready", {63'd0, p_ready},  64'd0);
    check("arst_m_ready", {63'd0, m_ready},  64'd0);
    step();
    rstn = 1'b1;
    // Counter restarts from zero: P wins four times, then M.
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rearb_p_ready", {63'd0, p_ready}, 64'd1);
      check("rearb_m_ready", {63'd0, m_ready}, 64'd0);
      step();
      check("rearb_rf_wa", {59'd0, rf_wa}, 64'd2);
    end
    #1;
    check("rearb_force_m", {63'd0, m_ready}, 64'd1);
    step();
    check("rearb_rf_wa_m",  {59'd0, rf_wa},    64'd9);
    check("rearb_forced_m", {63'd0, m_forced}, 64'd1);

    p_valid = 1'b0;
    m_valid = 1'b0;
    step();
    check("end_rf_we", {63'd0, rf_we}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
